// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined bf16 multiplier among NREQ requesters.
// A tag pipeline follows each issued pair so its product is returned to the requester that sent it.
module bf16_mul_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          mul_in,
    output logic                 mul_stb,
    input  logic [15:0]          mul_z,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_z,
    output logic [3:0]           inflight,
    output logic                 idle
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_id;
    logic [PW-1:0] iss_id;
    logic          found;
    logic          hs;
    logic          resp_any;
    logic [CW-1:0] inflight_nxt;

    logic [DW-1:0]      data_arr [NREQ];
    logic [LATENCY-1:0] tag_v;
    logic [PW-1:0]      tag_id   [LATENCY];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DW +: DW];
    end

    // First valid requester at or after ptr, wrapping; grant is gated by en and reset.
    always_comb begin
        found     = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[PW'((32'(ptr) + k) % NREQ)]) begin
                found    = 1'b1;
                grant_id = PW'((32'(ptr) + k) % NREQ);
            end
        end
        if (found && en && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign hs       = |req_ready;
    assign resp_any = |resp_valid;

    // Occupancy count: issue adds one, a returned product removes one.
    always_comb begin
        inflight_nxt = inflight;
        case ({hs, resp_any})
            2'b10:   inflight_nxt = inflight + CW'(1);
            2'b01:   inflight_nxt = inflight - CW'(1);
            default: inflight_nxt = inflight;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            mul_stb    <= 1'b0;
            mul_in     <= '0;
            iss_id     <= '0;
            tag_v      <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
            resp_valid <= '0;
            resp_z     <= '0;
            inflight   <= '0;
            idle       <= 1'b1;
        end else begin
            mul_stb <= hs;
            if (hs) begin
                mul_in <= data_arr[grant_id];
                iss_id <= grant_id;
                ptr    <= PW'((32'(grant_id) + 1) % NREQ);
            end

            // Tags advance every cycle in lockstep with the multiplier; no stall exists.
            tag_v[0]  <= mul_stb;
            tag_id[0] <= iss_id;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end

            if (tag_v[LATENCY-1]) begin
                resp_valid <= NREQ'(1) << tag_id[LATENCY-1];
                resp_z     <= mul_z;
            end else begin
                resp_valid <= '0;
            end

            inflight <= inflight_nxt;
            idle     <= (inflight_nxt == '0) && !hs;
        end
    end

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Self-checking bench: round-robin/latency reference model with a scoreboard of expected returns,
// driving directed scenarios followed by randomized traffic, enable drops and resets.
module tb_bf16_mul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*32-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        mul_in;
    logic               mul_stb;
    logic [15:0]        mul_z;
    logic [NREQ-1:0]    resp_valid;
    logic [15:0]        resp_z;
    logic [3:0]         inflight;
    logic               idle;

    bf16_mul_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .mul_in(mul_in), .mul_stb(mul_stb), .mul_z(mul_z),
        .resp_valid(resp_valid), .resp_z(resp_z),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Truncating bf16 multiply for normal operands; zero/denormal inputs give signed zero.
    function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [8:0]  e;
        logic        s;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'h0 || b[14:7] == 8'h0) return {s, 15'h0};
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = 9'(a[14:7]) + 9'(b[14:7]) - 9'd127;
        if (p[15]) begin
            e = e + 9'd1;
            return {s, e[7:0], p[14:8]};
        end
        return {s, e[7:0], p[13:7]};
    endfunction

    // Stand-in for the shared 3-stage multiplier.
    logic [15:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= bf_mul(mul_in[31:16], mul_in[15:0]);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_z = mpipe[LAT-1];

    typedef struct {
        int          id;
        logic [15:0] z;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          m_ptr = 0;
    logic        m_stb = 1'b0;
    logic [31:0] m_in = '0;
    logic [15:0] m_z = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic r, input logic e, input logic [NREQ-1:0] v,
                        input logic [NREQ*32-1:0] d);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        exp_t            ent;
        @(posedge clk);
        #1;
        rst = r; en = e; req_valid = v; req_data = d;
        @(negedge clk);
        g = model_grant(v, m_ptr);
        exp_rdy = (!r && e && g >= 0) ? NREQ'(1) << g : '0;
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv = NREQ'(1) << sb[0].id;
            m_z    = sb[0].z;
        end
        check("req_ready",  32'(req_ready),  32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(exp_rv));
        check("resp_z",     32'(resp_z),     32'(m_z));
        check("inflight",   32'(inflight),   32'(sb.size()));
        check("mul_stb",    32'(mul_stb),    32'(m_stb));
        check("mul_in",     mul_in,          m_in);
        check("idle",       32'(idle),       32'(sb.size() == 0 && !m_stb));
        if (exp_rv != '0) void'(sb.pop_front());
        if (r) begin
            sb.delete();
            m_ptr = 0; m_stb = 1'b0; m_in = '0; m_z = '0;
        end else begin
            m_stb = (exp_rdy != '0);
            if (m_stb) begin
                m_in    = d[g*32 +: 32];
                ent.id  = g;
                ent.z   = bf_mul(m_in[31:16], m_in[15:0]);
                ent.due = cyc + LAT + 2;
                sb.push_back(ent);
                m_ptr = (g + 1) % NREQ;
            end
        end
        cyc++;
    endtask

    logic [NREQ*32-1:0] d;

    initial begin
        d = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, d);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'b0000, d);

        // Single request from requester 2: 1.0 x 2.0
        d = '0;
        d[2*32 +: 32] = {16'h3F80, 16'h4000};
        step(1'b0, 1'b1, 4'b0100, d);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b0000, d);

        // Requester 1: 3.0 x -1.5
        d = '0;
        d[1*32 +: 32] = {16'h4040, 16'hBFC0};
        step(1'b0, 1'b1, 4'b0010, d);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b0000, d);

        // All requesters continuously valid with distinct operands
        d = {16'h4080, 16'h3FC0, 16'h4040, 16'h4000, 16'hC000, 16'h3F80, 16'h3F00, 16'h4100};
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'b1111, d);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0000, d);

        // Enable low with everyone requesting, then resume from the saved pointer
        step(1'b0, 1'b1, 4'b0001, d);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b1111, d);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1111, d);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b0000, d);

        // Three back-to-back issues, reset the cycle after the last strobe
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1111, d);
        step(1'b0, 1'b1, 4'b0000, d);
        step(1'b1, 1'b1, 4'b0000, d);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b0000, d);

        // Lone requester 3 streaming: pointer wraps every cycle, inflight saturates
        d = '0;
        d[3*32 +: 32] = {16'h4040, 16'h4040};
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'b1000, d);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b0000, d);

        // Randomized traffic with occasional enable drops and resets
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom % 60) == 0, ($urandom % 8) != 0, NREQ'($urandom), d);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'b0000, d);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bf16_mul_arbiter.md
# bf16_mul_arbiter

Round-robin arbiter and sequencer that shares one 3-stage pipelined bf16 multiplier among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier. A tag pipeline tracks each operation through the multiplier's fixed latency, and the block returns each product to the requester that issued it. It sits between the multiply-node requesters and the shared multiplier instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `LATENCY`, 3: cycles from the multiplier strobe cycle to a valid `mul_z`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: grant enable. When low, no new grants are made; operations already in flight still complete.
- `req_valid` in NREQ: requester i has an operand pair.
- `req_data` in NREQ*32: slice i is `{a[15:0], b[15:0]}` in bf16.
- `req_ready` out NREQ: one-hot grant, combinational.
- `mul_in` out 32: operand pair to the multiplier, `{a, b}`.
- `mul_stb` out 1: operand strobe to the multiplier.
- `mul_z` in 16: multiplier product. The multiplier's own output strobe is not used.
- `resp_valid` out NREQ: one-hot result strobe, held for 1 cycle.
- `resp_z` out 16: bf16 product for the requester flagged in `resp_valid`.
- `inflight` out 4: number of operations issued and not yet returned.
- `idle` out 1: high when `inflight==0` and `mul_stb==0`.

## Operation
- Arbitration:
  - Priority pointer `ptr` (log2 NREQ bits). Requester `ptr` has highest priority, then `ptr+1`, and so on, wrapping modulo NREQ.
  - `req_ready[i]=1` only for the first i in that order with `req_valid[i]=1`, and only when `en=1` and `rst=0`. At most one bit of `req_ready` is set.
  - A handshake is `req_valid[i] & req_ready[i]`. On a handshake, `ptr` becomes `(i+1) mod NREQ`. With no handshake, `ptr` holds.
- Issue: on a handshake, the block registers `mul_in <= req_data[i]`, `mul_stb <= 1` and tag id `i`. With no handshake, `mul_stb <= 0` and `mul_in` holds.
- Tag pipeline:
  - LATENCY-deep shift register of `{valid, id}`, loaded from `{mul_stb, issued id}` and shifted every cycle.
  - There is no stall: the multiplier cannot be back-pressured.
  - At the tail, the block registers `resp_z <= mul_z` and `resp_valid <= onehot(id)` if the tail entry is valid, else `resp_valid <= 0`. `resp_z` holds when no result returns.
- Requesters must accept `resp_valid` unconditionally. There is no response back-pressure.
- `inflight`:
  - +1 on a handshake, −1 on `resp_valid` (any bit set).
  - Both in the same cycle: unchanged.
  - Maximum value is LATENCY+2, which fits in 4 bits.
- Products are returned in issue order. Special values (NaN, inf, zero) are passed through exactly as the multiplier produces them.

## Timing
- Handshake in cycle c gives `mul_stb`/`mul_in` in cycle c+1. `mul_z` is valid in cycle c+1+LATENCY, and `resp_valid`/`resp_z` are valid in cycle c+2+LATENCY. That is cycle c+5 at the default LATENCY.
- Throughput: 1 operation per cycle. Back-to-back handshakes produce back-to-back responses.
- Reset values:
  - `ptr=0`, `mul_stb=0`, `mul_in=0`.
  - Tag pipeline all invalid.
  - `resp_valid=0`, `resp_z=0`, `inflight=0`, `idle=1`.
  - `req_ready=0` while `rst=1`.
- Reset mid-operation: all in-flight tags are discarded, so no `resp_valid` fires for them after reset. Stale `mul_z` values are ignored.
- `en` falling in cycle c: no handshake in cycle c. Operations already issued return on schedule.
- A requester that drops `req_valid` without a handshake loses nothing; no state is kept for it.

## Test plan
- Single request, NREQ=4: requester 2 presents `{0x3F80, 0x4000}` (1.0×2.0) in cycle 5 -> `req_ready=0100` in cycle 5; `mul_stb` high in cycle 6; `resp_valid=0100`, `resp_z=0x4000` in cycle 10; `inflight` reads 1 from cycle 6 through cycle 10 and 0 afterwards.
- All four requesters valid continuously from cycle 0, each holding distinct data -> grants in the order 0,1,2,3,0,1,… one per cycle; `resp_valid` follows the same order starting 5 cycles after the first grant, with each `resp_z` matching its own requester's product.
- Requester 1 presents `{0x4040, 0xBFC0}` (3.0×−1.5) -> `resp_valid=0010` with `resp_z=0xC090`, exactly 5 cycles after the handshake.
- `en=0` for 10 cycles with all requesters valid -> `req_ready=0` throughout and `mul_stb=0`; once `en` returns high, the grant goes to the `ptr` value saved when `en` fell.
- Issue 3 back-to-back operations, then assert `rst` for 1 cycle in the cycle after the last `mul_stb` -> no `resp_valid` is ever produced for them; `inflight=0` and `idle=1` in the cycle after reset.
- Only requester 3 valid, continuously -> grants every cycle (pointer wraps 3→0 and the search reaches 3 again); `inflight` saturates at 5 with `resp_valid` firing every cycle.
